// File: rtl/hilo_mul_sequencer.sv
// HI/LO register pair with a multi-cycle multiply sequencer (mult/multu/madd/msub)
// and single-cycle mthi/mtlo/mfhi/mflo; raises Stall while a multiply is in flight.
module hilo_mul_sequencer #(
  parameter int MUL_LATENCY = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [5:0]  ALUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Flush,
  output logic        Stall,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic [31:0] ReadData
);
  localparam logic [5:0] OP_MULT  = 6'b000101;
  localparam logic [5:0] OP_MULTU = 6'b000110;
  localparam logic [5:0] OP_MADD  = 6'b000111;
  localparam logic [5:0] OP_MSUB  = 6'b001000;
  localparam logic [5:0] OP_MTHI  = 6'b001010;
  localparam logic [5:0] OP_MTLO  = 6'b001011;
  localparam logic [5:0] OP_MFHI  = 6'b001100;
  localparam logic [5:0] OP_MFLO  = 6'b001101;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [5:0]  op_q, op_d;
  logic        done_q, done_d;

  logic        is_mul, is_hilo;
  logic signed [63:0] prod_s;
  logic [63:0] prod_u, acc, result;

  assign is_mul  = (ALUOp == OP_MULT) || (ALUOp == OP_MULTU) ||
                   (ALUOp == OP_MADD) || (ALUOp == OP_MSUB);
  assign is_hilo = is_mul || (ALUOp == OP_MTHI) || (ALUOp == OP_MTLO) ||
                   (ALUOp == OP_MFHI) || (ALUOp == OP_MFLO);

  assign Busy     = (state_q == BUSY);
  assign Stall    = Start && is_hilo && Busy;
  assign Done     = done_q;
  assign Hi       = hi_q;
  assign Lo       = lo_q;
  assign ReadData = (ALUOp == OP_MFHI) ? hi_q :
                    (ALUOp == OP_MFLO) ? lo_q : 32'd0;

  // Accumulate ops read {Hi,Lo} at commit; the interlock keeps it equal to the issue-time value.
  always_comb begin
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    acc    = {hi_q, lo_q};
    case (op_q)
      OP_MULTU: result = prod_u;
      OP_MADD:  result = acc + $unsigned(prod_s);
      OP_MSUB:  result = acc - $unsigned(prod_s);
      default:  result = $unsigned(prod_s);
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          if (is_mul) begin
            a_d     = A;
            b_d     = B;
            op_d    = ALUOp;
            cnt_d   = 5'(MUL_LATENCY - 1);
            state_d = BUSY;
          end else if (ALUOp == OP_MTHI) begin
            hi_d   = A;
            done_d = 1'b1;
          end else if (ALUOp == OP_MTLO) begin
            lo_d   = A;
            done_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (Flush) begin
          state_d = IDLE;
        end else if (cnt_q == 5'd0) begin
          {hi_d, lo_d} = result;
          done_d       = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_hilo_mul_sequencer.sv
// Directed plus randomized bench for hilo_mul_sequencer against a transaction-level
// model: a pending multiply commits L edges after acceptance using plain 64-bit math.
module tb_hilo_mul_sequencer;
  localparam int L = 4;
  localparam logic [5:0] MULT = 6'b000101, MULTU = 6'b000110, MADD = 6'b000111,
                         MSUB = 6'b001000, MTHI  = 6'b001010, MTLO = 6'b001011,
                         MFHI = 6'b001100, MFLO  = 6'b001101, NOP  = 6'b000000;

  logic        Clk = 0, Reset = 0, Start = 0, Flush = 0;
  logic [5:0]  ALUOp = 0;
  logic [31:0] A = 0, B = 0;
  logic        Stall, Busy, Done;
  logic [31:0] Hi, Lo, ReadData;

  hilo_mul_sequencer #(.MUL_LATENCY(L)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ALUOp(ALUOp), .A(A), .B(B),
    .Flush(Flush), .Stall(Stall), .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo),
    .ReadData(ReadData));

  always #5 Clk = ~Clk;

  int n_checks = 0, n_fail = 0;

  // reference model state
  logic [31:0] m_hi = 0, m_lo = 0, m_a = 0, m_b = 0;
  logic [5:0]  m_op = 0;
  bit          m_busy = 0, m_done = 0, last_stall = 0;
  int          cyc = 0, m_commit = 0;

  function automatic bit is_mul(input logic [5:0] op);
    return op == MULT || op == MULTU || op == MADD || op == MSUB;
  endfunction
  function automatic bit is_hilo(input logic [5:0] op);
    return is_mul(op) || op == MTHI || op == MTLO || op == MFHI || op == MFLO;
  endfunction

  function automatic logic [63:0] ref_result(input logic [5:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] hl);
    longint sp;
    logic [63:0] up;
    sp = longint'($signed(a)) * longint'($signed(b));
    up = {32'd0, a} * {32'd0, b};
    case (op)
      MULTU:   return up;
      MADD:    return hl + 64'(sp);
      MSUB:    return hl - 64'(sp);
      default: return 64'(sp);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit s, input logic [5:0] op, input logic [31:0] a,
                            input logic [31:0] b, input bit f);
    logic [63:0] r;
    cyc++;
    m_done = 0;
    if (m_busy) begin
      if (f) m_busy = 0;
      else if (cyc == m_commit) begin
        r = ref_result(m_op, m_a, m_b, {m_hi, m_lo});
        {m_hi, m_lo} = r;
        m_busy = 0;
        m_done = 1;
      end
    end else if (s) begin
      if (is_mul(op)) begin
        m_busy = 1; m_commit = cyc + L; m_op = op; m_a = a; m_b = b;
      end else if (op == MTHI) begin
        m_hi = a; m_done = 1;
      end else if (op == MTLO) begin
        m_lo = a; m_done = 1;
      end
    end
  endtask

  // One clock: drive, check combinational outputs, clock, check registered outputs.
  task automatic step(input bit s, input logic [5:0] op, input logic [31:0] a,
                      input logic [31:0] b, input bit f);
    bit exp_stall;
    logic [31:0] exp_rd;
    Start = s; ALUOp = op; A = a; B = b; Flush = f;
    #1;
    exp_stall = s && is_hilo(op) && m_busy;
    exp_rd = (op == MFHI) ? m_hi : (op == MFLO) ? m_lo : 32'd0;
    chk("stall", {31'd0, Stall}, {31'd0, exp_stall});
    chk("rdata", ReadData, exp_rd);
    last_stall = exp_stall;
    @(posedge Clk);
    model_edge(s, op, a, b, f);
    #1;
    chk("busy", {31'd0, Busy}, {31'd0, m_busy});
    chk("done", {31'd0, Done}, {31'd0, m_done});
    chk("hi", Hi, m_hi);
    chk("lo", Lo, m_lo);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, NOP, 0, 0, 0);
  endtask

  logic [5:0] ops [10] = '{MULT, MULTU, MADD, MSUB, MTHI, MTLO, MFHI, MFLO, NOP, 6'h3F};

  initial begin
    bit s, f;
    logic [5:0] op;
    logic [31:0] a, b;
    int stalls;

    // reset state
    @(posedge Clk); #1;
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_hi", Hi, 32'd0);
    chk("rst_lo", Lo, 32'd0);
    Reset = 1;
    idle(1);

    // async reset in the middle of a multiply discards it
    step(1, MTHI, 32'h1234, 0, 0);
    step(1, MULT, 7, 6, 0);
    idle(1);
    #2 Reset = 0;
    #1;
    m_hi = 0; m_lo = 0; m_busy = 0; m_done = 0;
    chk("arst_busy", {31'd0, Busy}, 32'd0);
    chk("arst_hi", Hi, 32'd0);
    chk("arst_lo", Lo, 32'd0);
    @(posedge Clk); #1 Reset = 1;
    idle(6);

    // signed / unsigned products
    step(1, MULT, 32'hFFFFFFFF, 2, 0);
    idle(L);
    chk("mult_hi", Hi, 32'hFFFFFFFF);
    chk("mult_lo", Lo, 32'hFFFFFFFE);
    idle(1);
    step(1, MULTU, 32'hFFFFFFFF, 2, 0);
    idle(L);
    chk("multu_hi", Hi, 32'h00000001);
    chk("multu_lo", Lo, 32'hFFFFFFFE);

    // madd carry from LO into HI
    step(1, MTHI, 0, 0, 0);
    step(1, MTLO, 32'hFFFFFFFF, 0, 0);
    step(1, MADD, 1, 1, 0);
    idle(L);
    chk("madd_hi", Hi, 32'd1);
    chk("madd_lo", Lo, 32'd0);

    // mflo right after a mult stalls until the multiply completes
    step(1, MULT, 32'd5, 32'd9, 0);
    stalls = 0;
    do begin
      step(1, MFLO, 0, 0, 0);
      if (last_stall) stalls++;
    end while (last_stall && stalls < 20);
    chk("mflo_stalls", stalls, L);
    chk("mflo_after", Lo, 32'd45);

    // flush kills the multiply: no commit, no Done
    step(1, MTHI, 32'hAAAA5555, 0, 0);
    step(1, MULT, 3, 3, 0);
    step(0, NOP, 0, 0, 0);
    step(0, NOP, 0, 0, 1);
    idle(L + 1);
    chk("flush_hi", Hi, 32'hAAAA5555);
    chk("flush_lo", Lo, 32'd45);

    // flush with a simultaneous HI/LO op: stalls once, then accepted
    step(1, MSUB, 32'h10, 32'h3, 0);
    step(1, MTLO, 32'h77, 0, 1);
    chk("flush_start_stall", {31'd0, last_stall}, 32'd1);
    step(1, MTLO, 32'h77, 0, 0);
    idle(1);

    // randomized traffic, holding inputs while stalled
    s = 0; op = NOP; a = 0; b = 0;
    for (int i = 0; i < 400; i++) begin
      if (!last_stall) begin
        s  = ($urandom_range(0, 3) != 0);
        op = ops[$urandom_range(0, 9)];
        a  = $urandom;
        b  = ($urandom_range(0, 3) == 0) ? 32'(-$urandom_range(0, 5)) : $urandom;
      end
      f = ($urandom_range(0, 9) == 0);
      step(s, op, a, b, f);
    end
    idle(L + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
